// File: rtl/com_csr_demux.sv
// com_csr_demux: one-to-NUM_SLV CSR request router.
// Decodes each upstream request against per-slave base/mask windows and forwards
// it to a single slave. Returns an error response for unmapped addresses, for
// slaves previously marked dead, or when a slave exceeds the response timeout.
// Only one transaction is in flight at a time.
module com_csr_demux #(
  parameter int unsigned           AW       = 20,
  parameter int unsigned           DW       = 32,
  parameter int unsigned           NUM_SLV  = 4,
  parameter logic [NUM_SLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*AW-1:0] SLV_MASK = '0,
  parameter int unsigned           TIMEOUT  = 1024,
  parameter logic [31:0]           ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  rx_req_vld,
  output logic                  rx_req_rdy,
  input  logic [AW-1:0]         rx_req_addr,
  input  logic                  rx_req_wr,
  input  logic [DW-1:0]         rx_req_wdata,
  input  logic [DW/8-1:0]       rx_req_strb,
  output logic                  rx_rsp_vld,
  input  logic                  rx_rsp_rdy,
  output logic [DW-1:0]         rx_rsp_rdata,
  output logic                  rx_rsp_err,
  output logic [NUM_SLV-1:0]    tx_req_vld,
  input  logic [NUM_SLV-1:0]    tx_req_rdy,
  output logic [AW-1:0]         tx_req_addr,
  output logic                  tx_req_wr,
  output logic [DW-1:0]         tx_req_wdata,
  output logic [DW/8-1:0]       tx_req_strb,
  input  logic [NUM_SLV-1:0]    tx_rsp_vld,
  input  logic [NUM_SLV*DW-1:0] tx_rsp_rdata,
  input  logic [NUM_SLV-1:0]    tx_rsp_err,
  output logic [NUM_SLV-1:0]    sta_dead,
  output logic                  evt_timeout
);

  localparam int unsigned   SW       = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned   CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            TO_EN    = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [DW-1:0] ERR_WORD = DW'(ERR_DATA);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_ERR  = 3'd3,
    ST_RSP  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               wr_q, wr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW/8-1:0]    strb_q, strb_d;
  logic [SW-1:0]      sel_q, sel_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [NUM_SLV-1:0] dead_q, dead_d;
  logic               evt_q, evt_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               dec_hit;
  logic [SW-1:0]      dec_sel;
  logic               rsp_hit;
  logic               expire;

  // Address decode, lowest matching index wins. Evaluated on the address being
  // accepted, which is exactly the value latched into addr_q, so the REQ/ERR
  // decision can be made in the accept cycle.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (!dec_hit &&
          ((rx_req_addr & SLV_MASK[i*AW +: AW]) ==
           (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]))) begin
        dec_hit = 1'b1;
        dec_sel = SW'(i);
      end
    end
  end

  // Response from the selected slave: in WAIT, or coincident with the accepting ready in REQ.
  always_comb begin
    rsp_hit = tx_rsp_vld[sel_q] &&
              ((state_q == ST_WAIT) || ((state_q == ST_REQ) && tx_req_rdy[sel_q]));
    expire  = TO_EN && ((state_q == ST_REQ) || (state_q == ST_WAIT)) &&
              (cnt_q == CNT_LAST) && !rsp_hit;
  end

  // Next-state logic; clear overrides everything with the reset values.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    dead_d  = dead_q;
    evt_d   = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_req_vld) begin
          addr_d  = rx_req_addr;
          wr_d    = rx_req_wr;
          wdata_d = rx_req_wdata;
          strb_d  = rx_req_strb;
          sel_d   = dec_sel;
          cnt_d   = '0;
          if (!dec_hit || dead_q[dec_sel]) state_d = ST_ERR;
          else                             state_d = ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (rsp_hit) begin
          rdata_d = tx_rsp_rdata[sel_q*DW +: DW];
          err_d   = tx_rsp_err[sel_q];
          state_d = ST_RSP;
        end else if (expire) begin
          dead_d[sel_q] = 1'b1;
          evt_d         = 1'b1;
          rdata_d       = ERR_WORD;
          err_d         = 1'b1;
          state_d       = ST_RSP;
        end else if ((state_q == ST_REQ) && tx_req_rdy[sel_q]) begin
          state_d = ST_WAIT;
        end
      end
      ST_ERR: begin
        rdata_d = ERR_WORD;
        err_d   = 1'b1;
        state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rx_rsp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      wr_d    = 1'b0;
      wdata_d = '0;
      strb_d  = '0;
      sel_d   = '0;
      rdata_d = '0;
      err_d   = 1'b0;
      dead_d  = '0;
      evt_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      dead_q  <= '0;
      evt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      dead_q  <= dead_d;
      evt_q   <= evt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-slave request valid: one-hot on the latched select while in REQ.
  always_comb begin
    tx_req_vld = '0;
    if (state_q == ST_REQ) tx_req_vld[sel_q] = 1'b1;
  end

  assign rx_req_rdy   = (state_q == ST_IDLE);
  assign rx_rsp_vld   = (state_q == ST_RSP);
  assign rx_rsp_rdata = rdata_q;
  assign rx_rsp_err   = err_q;
  assign tx_req_addr  = addr_q;
  assign tx_req_wr    = wr_q;
  assign tx_req_wdata = wdata_q;
  assign tx_req_strb  = strb_q;
  assign sta_dead     = dead_q;
  assign evt_timeout  = evt_q;

endmodule

// File: tb/tb_com_csr_demux.sv
// Directed, table-driven bench for com_csr_demux (4 slaves, TIMEOUT=16).
// Slave windows: s0 0x30000/0xFF000, s1 0x10000/0xF0000,
//                s2 0x20000/0xF0000, s3 0x30000/0xF0000 (s0 shadows 0x30xxx).
module tb_com_csr_demux;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam logic [NS*AW-1:0] BASE = {20'h30000, 20'h20000, 20'h10000, 20'h30000};
  localparam logic [NS*AW-1:0] MASK = {20'hF0000, 20'hF0000, 20'hF0000, 20'hFF000};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             rx_req_vld = 1'b0;
  logic             rx_req_rdy;
  logic [AW-1:0]    rx_req_addr = '0;
  logic             rx_req_wr = 1'b0;
  logic [DW-1:0]    rx_req_wdata = '0;
  logic [DW/8-1:0]  rx_req_strb = '0;
  logic             rx_rsp_vld;
  logic             rx_rsp_rdy = 1'b0;
  logic [DW-1:0]    rx_rsp_rdata;
  logic             rx_rsp_err;
  logic [NS-1:0]    tx_req_vld;
  logic [NS-1:0]    tx_req_rdy = '0;
  logic [AW-1:0]    tx_req_addr;
  logic             tx_req_wr;
  logic [DW-1:0]    tx_req_wdata;
  logic [DW/8-1:0]  tx_req_strb;
  logic [NS-1:0]    tx_rsp_vld = '0;
  logic [NS*DW-1:0] tx_rsp_rdata = '0;
  logic [NS-1:0]    tx_rsp_err = '0;
  logic [NS-1:0]    sta_dead;
  logic             evt_timeout;

  com_csr_demux #(
    .AW(AW), .DW(DW), .NUM_SLV(NS), .SLV_BASE(BASE), .SLV_MASK(MASK),
    .TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .rx_req_vld(rx_req_vld), .rx_req_rdy(rx_req_rdy), .rx_req_addr(rx_req_addr),
    .rx_req_wr(rx_req_wr), .rx_req_wdata(rx_req_wdata), .rx_req_strb(rx_req_strb),
    .rx_rsp_vld(rx_rsp_vld), .rx_rsp_rdy(rx_rsp_rdy), .rx_rsp_rdata(rx_rsp_rdata),
    .rx_rsp_err(rx_rsp_err),
    .tx_req_vld(tx_req_vld), .tx_req_rdy(tx_req_rdy), .tx_req_addr(tx_req_addr),
    .tx_req_wr(tx_req_wr), .tx_req_wdata(tx_req_wdata), .tx_req_strb(tx_req_strb),
    .tx_rsp_vld(tx_rsp_vld), .tx_rsp_rdata(tx_rsp_rdata), .tx_rsp_err(tx_rsp_err),
    .sta_dead(sta_dead), .evt_timeout(evt_timeout)
  );

  always #5 clk = ~clk;

  // sel=-1: no slave may see a request. rdy_dly: cycles of tx_req_vld before ready
  // (999 = never). rsp_dly: cycles after acceptance for the response pulse.
  // exp_lat: cycles from the accept edge to the first cycle showing rx_rsp_vld.
  typedef struct {
    logic [19:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          sel;
    int          rdy_dly;
    int          rsp_dly;
    logic [31:0] srdata;
    logic        serr;
    int          hold;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_vld;
    int          exp_evt;
    logic [3:0]  exp_dead;
  } vec_t;

  vec_t vt[12];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int         j = 1;
    int         vldcyc = 0;
    int         evtcnt = 0;
    int         acc_j = 0;
    bit         acc = 1'b0;
    bit         done = 1'b0;
    logic [3:0] exp_oh;
    exp_oh = (v.sel < 0) ? 4'b0000 : 4'(1 << v.sel);
    chk("idle_req_rdy", 32'(rx_req_rdy), 32'd1);
    rx_req_vld = 1'b1; rx_req_addr = v.addr; rx_req_wr = v.wr;
    rx_req_wdata = v.wdata; rx_req_strb = v.strb;
    @(negedge clk);
    rx_req_vld = 1'b0; rx_req_addr = '0; rx_req_wr = 1'b0;
    rx_req_wdata = '0; rx_req_strb = '0;
    while (!done && j <= 40) begin
      tx_req_rdy = '0; tx_rsp_vld = '0; tx_rsp_err = '0;
      if (evt_timeout) evtcnt++;
      if (rx_rsp_vld) begin
        done = 1'b1;
      end else begin
        if (tx_req_vld != '0) begin
          if (vldcyc == 0) begin
            chk("tx_req_vld_onehot", 32'(tx_req_vld), 32'(exp_oh));
            chk("tx_req_addr", 32'(tx_req_addr), 32'(v.addr));
            chk("tx_req_wr", 32'(tx_req_wr), 32'(v.wr));
            chk("tx_req_wdata", tx_req_wdata, v.wdata);
            chk("tx_req_strb", 32'(tx_req_strb), 32'(v.strb));
          end
          if (!acc && v.sel >= 0 && vldcyc == v.rdy_dly) begin
            tx_req_rdy[v.sel] = 1'b1;
            acc = 1'b1;
            acc_j = j;
          end
          vldcyc++;
        end
        if (acc && j == acc_j + v.rsp_dly) begin
          tx_rsp_vld[v.sel] = 1'b1;
          tx_rsp_rdata[v.sel*32 +: 32] = v.srdata;
          tx_rsp_err[v.sel] = v.serr;
        end
        @(negedge clk);
        j++;
      end
    end
    if (!done) chk("rsp_wait_bound", 32'd0, 32'd1);
    chk("rsp_latency", 32'(j), 32'(v.exp_lat));
    chk("rsp_rdata", rx_rsp_rdata, v.exp_rdata);
    chk("rsp_err", 32'(rx_rsp_err), 32'(v.exp_err));
    for (int h = 0; h < v.hold; h++) begin
      rx_req_vld = 1'b1; rx_req_addr = 20'hF0000;
      chk("hold_rsp_vld", 32'(rx_rsp_vld), 32'd1);
      chk("hold_rsp_rdata", rx_rsp_rdata, v.exp_rdata);
      chk("hold_req_rdy", 32'(rx_req_rdy), 32'd0);
      chk("hold_tx_addr", 32'(tx_req_addr), 32'(v.addr));
      @(negedge clk);
      if (evt_timeout) evtcnt++;
    end
    rx_rsp_rdy = 1'b1;
    @(negedge clk);
    rx_rsp_rdy = 1'b0; rx_req_vld = 1'b0; rx_req_addr = '0;
    if (evt_timeout) evtcnt++;
    chk("post_rsp_vld", 32'(rx_rsp_vld), 32'd0);
    chk("post_req_rdy", 32'(rx_req_rdy), 32'd1);
    chk("post_tx_vld", 32'(tx_req_vld), 32'd0);
    chk("tx_vld_cycles", 32'(vldcyc), 32'(v.exp_vld));
    chk("evt_count", 32'(evtcnt), 32'(v.exp_evt));
    chk("sta_dead", 32'(sta_dead), 32'(v.exp_dead));
  endtask

  initial begin
    //        addr       wr    wdata         strb  sel rdy rsp srdata        serr hold lat rdata         err vld evt dead
    vt[0]  = '{20'h20010, 1'b1, 32'h12345678, 4'hF,  2,  0,  1, 32'h00000000, 1'b0, 0,  3, 32'h00000000, 1'b0, 1, 0, 4'b0000};
    vt[1]  = '{20'hF0000, 1'b0, 32'h00000000, 4'hF, -1,  0,  0, 32'h00000000, 1'b0, 0,  2, 32'hDEADBEEF, 1'b1, 0, 0, 4'b0000};
    vt[2]  = '{20'h10004, 1'b0, 32'h00000000, 4'hF,  1,  2,  3, 32'h11110001, 1'b0, 0,  7, 32'h11110001, 1'b0, 3, 0, 4'b0000};
    vt[3]  = '{20'h20008, 1'b0, 32'h00000000, 4'hF,  2,  0,  0, 32'hA5A5A5A5, 1'b1, 0,  2, 32'hA5A5A5A5, 1'b1, 1, 0, 4'b0000};
    vt[4]  = '{20'h30010, 1'b0, 32'h00000000, 4'hF,  0,  1,  1, 32'h0000C0DE, 1'b0, 5,  4, 32'h0000C0DE, 1'b0, 2, 0, 4'b0000};
    vt[5]  = '{20'h31000, 1'b1, 32'hCAFE0055, 4'h3,  3,  0,  2, 32'h00000000, 1'b0, 0,  4, 32'h00000000, 1'b0, 1, 0, 4'b0000};
    vt[6]  = '{20'h00000, 1'b0, 32'h00000000, 4'hF, -1,  0,  0, 32'h00000000, 1'b0, 0,  2, 32'hDEADBEEF, 1'b1, 0, 0, 4'b0000};
    vt[7]  = '{20'h10000, 1'b0, 32'h00000000, 4'hF,  1,  0, 15, 32'h5A5A0000, 1'b0, 0, 17, 32'h5A5A0000, 1'b0, 1, 0, 4'b0000};
    vt[8]  = '{20'h10020, 1'b0, 32'h00000000, 4'hF,  1, 999, 0, 32'h00000000, 1'b0, 0, 17, 32'hDEADBEEF, 1'b1, 16, 1, 4'b0010};
    vt[9]  = '{20'h10030, 1'b1, 32'h00000077, 4'h1, -1,  0,  0, 32'h00000000, 1'b0, 0,  2, 32'hDEADBEEF, 1'b1, 0, 0, 4'b0010};
    vt[10] = '{20'h3F000, 1'b0, 32'h00000000, 4'hF,  3,  0, 16, 32'h00000000, 1'b0, 0, 17, 32'hDEADBEEF, 1'b1, 1, 1, 4'b1010};
    vt[11] = '{20'h2FFFC, 1'b0, 32'h00000000, 4'hF,  2,  0,  1, 32'h600DF00D, 1'b0, 0,  3, 32'h600DF00D, 1'b0, 1, 0, 4'b1010};

    repeat (2) @(negedge clk);
    chk("rst_req_rdy", 32'(rx_req_rdy), 32'd1);
    chk("rst_rsp_vld", 32'(rx_rsp_vld), 32'd0);
    chk("rst_rsp_rdata", rx_rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rx_rsp_err), 32'd0);
    chk("rst_tx_vld", 32'(tx_req_vld), 32'd0);
    chk("rst_tx_addr", 32'(tx_req_addr), 32'd0);
    chk("rst_tx_wdata", tx_req_wdata, 32'd0);
    chk("rst_tx_wr_strb", 32'({tx_req_wr, tx_req_strb}), 32'd0);
    chk("rst_sta_dead", 32'(sta_dead), 32'd0);
    chk("rst_evt", 32'(evt_timeout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 12; k++) run_vec(vt[k]);

    // Clear while waiting for a response, then a late response must be ignored.
    rx_req_vld = 1'b1; rx_req_addr = 20'h20000; rx_req_wr = 1'b0;
    @(negedge clk);
    rx_req_vld = 1'b0;
    chk("clr_req_vld", 32'(tx_req_vld), 32'h4);
    tx_req_rdy[2] = 1'b1;
    @(negedge clk);
    tx_req_rdy = '0;
    chk("clr_wait_vld", 32'(tx_req_vld), 32'd0);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_rsp_vld", 32'(rx_rsp_vld), 32'd0);
    chk("clr_req_rdy", 32'(rx_req_rdy), 32'd1);
    chk("clr_sta_dead", 32'(sta_dead), 32'd0);
    chk("clr_tx_vld", 32'(tx_req_vld), 32'd0);
    chk("clr_tx_addr", 32'(tx_req_addr), 32'd0);
    tx_rsp_vld[2] = 1'b1; tx_rsp_rdata[64 +: 32] = 32'hBAD0BAD0;
    @(negedge clk);
    tx_rsp_vld = '0;
    chk("late_rsp_vld", 32'(rx_rsp_vld), 32'd0);
    chk("late_req_rdy", 32'(rx_req_rdy), 32'd1);
    @(negedge clk);
    chk("late_rsp_vld2", 32'(rx_rsp_vld), 32'd0);
    run_vec(vt[2]);

    // Asynchronous reset while a request is pending downstream.
    rx_req_vld = 1'b1; rx_req_addr = 20'h20000;
    @(negedge clk);
    rx_req_vld = 1'b0;
    chk("arst_pre_vld", 32'(tx_req_vld), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("arst_tx_vld", 32'(tx_req_vld), 32'd0);
    chk("arst_req_rdy", 32'(rx_req_rdy), 32'd1);
    chk("arst_rsp_vld", 32'(rx_rsp_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(vt[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
